// File: rtl/vga_sync_gen.sv
// VGA sync and pixel-coordinate generator: pixel clock-enable, h/v counters,
// sync pulses, display-active flag and frame-start strobe, all on CLK.
module vga_sync_gen #(
    parameter int   DIV      = 2,
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       CLK,
    input  logic       RESET,
    output logic       pix_ce,
    output logic [9:0] hcnt,
    output logic [9:0] vcnt,
    output logic       hsync,
    output logic       vsync,
    output logic       active,
    output logic       frame_start
);

    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]    H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0]    V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]    HS_BEG   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]    HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]    VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]    VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DW-1:0] r_div_cnt;
    logic          r_pix_ce;
    logic [9:0]    r_hcnt;
    logic [9:0]    r_vcnt;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_active;
    logic          r_frame_start;

    logic          w_step;
    logic          w_h_wrap;
    logic          w_v_wrap;
    logic [9:0]    w_hcnt_nxt;
    logic [9:0]    w_vcnt_nxt;

    // Decodes are taken from the next-state counters so they land in the
    // same cycle as the counter value they describe.
    always_comb begin
        w_step     = (r_div_cnt == DIV_LAST);
        w_h_wrap   = w_step && (r_hcnt == H_LAST);
        w_v_wrap   = w_h_wrap && (r_vcnt == V_LAST);
        w_hcnt_nxt = r_hcnt;
        w_vcnt_nxt = r_vcnt;
        if (w_step) begin
            w_hcnt_nxt = w_h_wrap ? 10'd0 : r_hcnt + 10'd1;
        end
        if (w_h_wrap) begin
            w_vcnt_nxt = w_v_wrap ? 10'd0 : r_vcnt + 10'd1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_div_cnt     <= '0;
            r_pix_ce      <= 1'b0;
            r_hcnt        <= 10'd0;
            r_vcnt        <= 10'd0;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_active      <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_div_cnt     <= w_step ? '0 : r_div_cnt + DW'(1);
            r_pix_ce      <= w_step;
            r_hcnt        <= w_hcnt_nxt;
            r_vcnt        <= w_vcnt_nxt;
            r_hsync       <= ((w_hcnt_nxt >= HS_BEG) && (w_hcnt_nxt <= HS_END)) ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= ((w_vcnt_nxt >= VS_BEG) && (w_vcnt_nxt <= VS_END)) ? SYNC_POL : ~SYNC_POL;
            r_active      <= (w_hcnt_nxt < H_ACT) && (w_vcnt_nxt < V_ACT);
            r_frame_start <= w_v_wrap;
        end
    end

    assign pix_ce      = r_pix_ce;
    assign hcnt        = r_hcnt;
    assign vcnt        = r_vcnt;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign active      = r_active;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Randomized-reset bench for vga_sync_gen: three timing configurations share
// CLK/RESET and are compared every cycle against an arithmetic timing model.
module tb_vga_sync_gen;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;

    logic       a_ce, a_hs, a_vs, a_act, a_fs;
    logic [9:0] a_h, a_v;
    logic       b_ce, b_hs, b_vs, b_act, b_fs;
    logic [9:0] b_h, b_v;
    logic       c_ce, c_hs, c_vs, c_act, c_fs;
    logic [9:0] c_h, c_v;

    int n_chk  = 0;
    int n_pass = 0;
    int k      = 0;   // CLK edges seen since reset release
    int b_frames = 0;

    always #10 CLK = ~CLK;

    vga_sync_gen u_a (
        .CLK(CLK), .RESET(RESET), .pix_ce(a_ce), .hcnt(a_h), .vcnt(a_v),
        .hsync(a_hs), .vsync(a_vs), .active(a_act), .frame_start(a_fs)
    );

    vga_sync_gen #(
        .DIV(2), .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
        .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0)
    ) u_b (
        .CLK(CLK), .RESET(RESET), .pix_ce(b_ce), .hcnt(b_h), .vcnt(b_v),
        .hsync(b_hs), .vsync(b_vs), .active(b_act), .frame_start(b_fs)
    );

    vga_sync_gen #(
        .DIV(1), .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b1)
    ) u_c (
        .CLK(CLK), .RESET(RESET), .pix_ce(c_ce), .hcnt(c_h), .vcnt(c_v),
        .hsync(c_hs), .vsync(c_vs), .active(c_act), .frame_start(c_fs)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s k=%0d: got %h expected %h", tag, k, obs, exp);
    endtask

    // Expected {pix_ce, hcnt, vcnt, hsync, vsync, active, frame_start} after
    // kk edges out of reset: one pixel step every div edges from the first.
    function automatic logic [31:0] model(input int kk, input int div,
        input int ha, input int hfp, input int hsw, input int hbp,
        input int va, input int vfp, input int vsw, input int vbp, input bit pol);
        int  ht, vt, steps, h, v;
        bit  ce, hs, vs, act, fs;
        ht    = ha + hfp + hsw + hbp;
        vt    = va + vfp + vsw + vbp;
        steps = kk / div;
        h     = steps % ht;
        v     = (steps / ht) % vt;
        ce    = (kk > 0) && (kk % div == 0);
        hs    = (h >= ha + hfp && h < ha + hfp + hsw) ? pol : !pol;
        vs    = (v >= va + vfp && v < va + vfp + vsw) ? pol : !pol;
        act   = (h < ha) && (v < va);
        fs    = ce && (h == 0) && (v == 0);
        return {7'd0, ce, 10'(h), 10'(v), hs, vs, act, fs};
    endfunction

    task automatic check_all(input string tag);
        check({tag, "_a"}, {7'd0, a_ce, a_h, a_v, a_hs, a_vs, a_act, a_fs},
              model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
        check({tag, "_b"}, {7'd0, b_ce, b_h, b_v, b_hs, b_vs, b_act, b_fs},
              model(k, 2, 16, 4, 6, 4, 8, 2, 2, 3, 1'b0));
        check({tag, "_c"}, {7'd0, c_ce, c_h, c_v, c_hs, c_vs, c_act, c_fs},
              model(k, 1, 10, 2, 3, 2, 5, 1, 2, 2, 1'b1));
    endtask

    task automatic cycle(input string tag);
        @(posedge CLK);
        if (!RESET) k++;
        @(negedge CLK);
        if (b_fs) b_frames++;
        check_all(tag);
    endtask

    // Assert reset partway through a CLK high phase and look before any edge.
    task automatic async_reset(input int hold);
        int d;
        d = $urandom_range(1, 8);
        @(posedge CLK);
        if (!RESET) k++;
        #(d);
        RESET = 1'b1;
        k = 0;
        #1;
        check_all("async_rst");
        for (int i = 0; i < hold; i++) cycle("in_rst");
        RESET = 1'b0;
    endtask

    initial begin
        #2 RESET = 1'b1;
        #1 check_all("rst0");
        for (int i = 0; i < 5; i++) cycle("in_rst");
        RESET = 1'b0;

        b_frames = 0;
        for (int i = 0; i < 3300; i++) cycle("run");
        check("b_frames", 32'(b_frames), 32'(3300 / (2 * 30 * 15)));

        for (int seg = 0; seg < 6; seg++) begin
            int len;
            len = $urandom_range(20, 1500);
            for (int i = 0; i < len; i++) cycle("seg");
            async_reset($urandom_range(1, 6));
        end
        for (int i = 0; i < 1000; i++) cycle("tail");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
